// File: rtl/keypad_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// keypad_pkg : scanner states, key codes and row/column code map
// Rev 1.0
// ----------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } state_e;

  localparam logic [3:0] KEY_NONE = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_ZERO = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;

  // Three keys per row, numbered from 1; C beats A beats E when several are high.
  function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                          input logic       col_c,
                                          input logic       col_a,
                                          input logic       col_e);
    logic [3:0] base;
    base = {2'b00, row_idx} * 4'd3;
    if (col_c)      key_code = base + 4'd1;
    else if (col_a) key_code = base + 4'd2;
    else if (col_e) key_code = base + 4'd3;
    else            key_code = KEY_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_ctrl_fifo.sv
`default_nettype none
// ----------------------------------------------------------------
// key_fifo : small 4-bit code buffer, push and pop may share a cycle
// Rev 1.0
// ----------------------------------------------------------------
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       pop,
  output logic [3:0] head_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full buffer still accepts push+pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/keypad_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// keypad_ctrl : 4x3 keypad row scanner with debounce and code FIFO
// Rev 1.0
// ----------------------------------------------------------------
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV   = 16'd50000,
  parameter int          DEB_TICKS  = 4,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       C,
  input  logic       A,
  input  logic       E,
  output logic       B,
  output logic       G,
  output logic       F,
  output logic       D,
  output logic       key_valid,
  output logic [3:0] key_data,
  input  logic       key_rd,
  output logic       key_int,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int               CNT_W      = $clog2(DEB_TICKS + 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_TICKS);
  localparam logic [15:0]      PRESC_LAST = SCAN_DIV - 16'd1;

  state_e           state_q, state_d;
  logic [15:0]      presc_q, presc_d;
  logic [3:0]       rows_q, rows_d;
  logic [3:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_int_q, key_int_d;
  logic             overflow_q, overflow_d;

  logic             tick, cols_any, same_code, cnt_done;
  logic             push_req, push_ok, push_drop;
  logic             fifo_full, fifo_empty;
  logic [1:0]       row_idx;
  logic [3:0]       cur_code, fifo_head, rows_next;
  logic [CNT_W-1:0] cnt_inc;

  assign tick      = (presc_q == PRESC_LAST);
  assign presc_d   = tick ? '0 : presc_q + 16'd1;
  assign cur_code  = key_code(row_idx, C, A, E);
  assign cols_any  = C | A | E;
  assign same_code = (cur_code == code_q);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign cnt_done  = (cnt_inc == DEB_LAST);
  assign rows_next = {rows_q[2:0], rows_q[3]};

  always_comb begin
    case (rows_q)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      presc_q    <= '0;
      rows_q     <= 4'b0001;
      code_q     <= KEY_NONE;
      cnt_q      <= '0;
      key_int_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      rows_q     <= rows_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      key_int_q  <= key_int_d;
      overflow_q <= overflow_d;
    end
  end

  // The row only moves on when the scanner is back in SCAN with nothing pending.
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (cols_any) begin
            code_d  = cur_code;
            cnt_d   = '0;
            state_d = ST_DEB_PRESS;
          end else begin
            rows_d = rows_next;
          end
        end
        ST_DEB_PRESS: begin
          if (same_code) begin
            cnt_d = cnt_inc;
            if (cnt_done) state_d = ST_HELD;
          end else begin
            state_d = ST_SCAN;
            rows_d  = rows_next;
          end
        end
        ST_HELD: begin
          if (!cols_any) begin
            cnt_d   = '0;
            state_d = ST_DEB_REL;
          end
        end
        ST_DEB_REL: begin
          if (!cols_any) begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              state_d = ST_SCAN;
              rows_d  = rows_next;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // A full buffer only takes the code when the CPU pops in the same cycle.
  always_comb begin
    push_req   = (state_q == ST_DEB_PRESS) && tick && same_code && cnt_done;
    push_ok    = push_req && (!fifo_full || key_rd);
    push_drop  = push_req && fifo_full && !key_rd;
    key_int_d  = push_ok;
    overflow_d = push_drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_data(code_q),
    .pop      (key_rd),
    .head_data(fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {D, F, G, B} = rows_q;
  assign key_valid    = !fifo_empty;
  assign key_data     = fifo_empty ? KEY_NONE : fifo_head;
  assign key_int      = key_int_q;
  assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_keypad_ctrl : keypad emulation against a queue-based scanner model
// Rev 1.0
// ----------------------------------------------------------------
module tb_keypad_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int DEPTH    = 4;
  localparam int P_SCAN = 0, P_CONF = 1, P_HELD = 2, P_REL = 3;

  logic       clk = 1'b0;
  logic       rst, C, A, E, B, G, F, D;
  logic       key_valid, key_rd, key_int, overflow, ovf_clr;
  logic [3:0] key_data;

  keypad_ctrl #(
    .SCAN_DIV  (16'd4),
    .DEB_TICKS (DEB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .C        (C),
    .A        (A),
    .E        (E),
    .B        (B),
    .G        (G),
    .F        (F),
    .D        (D),
    .key_valid(key_valid),
    .key_data (key_data),
    .key_rd   (key_rd),
    .key_int  (key_int),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         row;
    logic [2:0] cols;
    logic [3:0] exp_data;
    logic       exp_valid;
    logic       exp_ovf;
  } press_vec_t;

  typedef struct {
    logic [3:0] exp_data;
    logic       exp_valid;
  } pop_vec_t;

  press_vec_t pv[5];
  pop_vec_t   popv[4];

  int errors = 0;
  int checks = 0;
  int int_cnt = 0;

  // stimulus: one pressed row with a column mask; s_* are the control inputs
  int         press_row;
  logic [2:0] press_cols;
  logic       s_rst, s_rd, s_clr;

  // reference model state
  int   m_presc, m_row, m_phase, m_code, m_stable;
  int   m_q[$];
  logic m_int, m_ovf;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_code(input int row, input logic [2:0] cols);
    if (cols == 3'b000) return 13;
    if (cols[0]) return row * 3 + 1;
    if (cols[1]) return row * 3 + 2;
    return row * 3 + 3;
  endfunction

  function automatic logic [2:0] cols_now();
    return (press_row == m_row) ? press_cols : 3'b000;
  endfunction

  function automatic bit accept_next();
    return (m_presc == SCAN_DIV - 1) && (m_phase == P_CONF) && (m_stable == DEB - 1) &&
           (model_code(m_row, cols_now()) == m_code);
  endfunction

  task automatic m_reset();
    m_presc = 0; m_row = 0; m_phase = P_SCAN; m_code = 13; m_stable = 0;
    m_q.delete(); m_int = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic [2:0] cols, input logic rd, input logic clr);
    int now, sz;
    bit tk, push, pop, drop;
    if (r) begin
      m_reset();
      return;
    end
    tk      = (m_presc == SCAN_DIV - 1);
    m_presc = tk ? 0 : m_presc + 1;
    now     = model_code(m_row, cols);
    push    = 0;
    if (tk) begin
      case (m_phase)
        P_SCAN:
          if (now != 13) begin m_code = now; m_stable = 0; m_phase = P_CONF; end
          else m_row = (m_row + 1) % 4;
        P_CONF:
          if (now == m_code) begin
            m_stable++;
            if (m_stable == DEB) begin push = 1; m_phase = P_HELD; end
          end else begin
            m_phase = P_SCAN; m_row = (m_row + 1) % 4;
          end
        P_HELD:
          if (cols == 3'b000) begin m_stable = 0; m_phase = P_REL; end
        P_REL:
          if (cols == 3'b000) begin
            m_stable++;
            if (m_stable == DEB) begin m_phase = P_SCAN; m_row = (m_row + 1) % 4; end
          end else m_phase = P_HELD;
        default: ;
      endcase
    end
    sz    = m_q.size();
    pop   = rd && (sz > 0);
    m_int = 1'b0;
    drop  = 0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) begin m_q.push_back(m_code); m_int = 1'b1; end
      else drop = 1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    logic [3:0] exp_rows;
    exp_rows = 4'b0001 << m_row;
    check("rows", 16'({D, F, G, B}), 16'(exp_rows));
    check("key_valid", 16'(key_valid), 16'(m_q.size() != 0));
    check("key_data", 16'(key_data), 16'((m_q.size() != 0) ? m_q[0] : 13));
    check("key_int", 16'(key_int), 16'(m_int));
    check("overflow", 16'(overflow), 16'(m_ovf));
  endtask

  // Drive just after a falling edge, step the model at the rising edge, compare at the next fall.
  task automatic cycle();
    logic [2:0] cols;
    cols = cols_now();
    C = cols[0]; A = cols[1]; E = cols[2];
    rst = s_rst; key_rd = s_rd; ovf_clr = s_clr;
    @(posedge clk);
    model_step(s_rst, cols, s_rd, s_clr);
    @(negedge clk);
    compare_all();
    if (key_int === 1'b1) int_cnt++;
  endtask

  task automatic press(input int row, input logic [2:0] cols, input int hold, input int rel);
    press_row = row; press_cols = cols;
    repeat (hold) cycle();
    press_row = -1;
    repeat (rel) cycle();
  endtask

  task automatic pop_one();
    s_rd = 1'b1;
    cycle();
    s_rd = 1'b0;
  endtask

  task automatic wait_row(input int r);
    int n = 0;
    while (!(m_row == r && m_presc == 0) && n < 100) begin cycle(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_row: row %0d never reached", r);
    end
    check("wait_row", 16'({D, F, G, B}), 16'(4'b0001 << r));
  endtask

  // Hold a key and raise rd/clr exactly on the tick that completes its debounce.
  task automatic press_sync(input int row, input logic [2:0] cols, input logic rd,
                            input logic clr, output bit found);
    found = 0;
    press_row = row; press_cols = cols;
    for (int i = 0; i < 80 && !found; i++) begin
      if (accept_next()) begin s_rd = rd; s_clr = clr; found = 1; end
      cycle();
      s_rd = 1'b0; s_clr = 1'b0;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL press_sync: no accepting tick for row %0d", row);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  c0;
    bit  found;
    int  exp9[4];

    pv[0] = '{0, 3'b111, 4'd1, 1'b1, 1'b0};
    pv[1] = '{0, 3'b110, 4'd1, 1'b1, 1'b0};
    pv[2] = '{0, 3'b100, 4'd1, 1'b1, 1'b0};
    pv[3] = '{1, 3'b001, 4'd1, 1'b1, 1'b0};
    pv[4] = '{1, 3'b100, 4'd1, 1'b1, 1'b1};
    popv[0] = '{4'd2, 1'b1};
    popv[1] = '{4'd3, 1'b1};
    popv[2] = '{4'd4, 1'b1};
    popv[3] = '{4'd13, 1'b0};
    exp9 = '{2, 3, 4, 9};

    m_reset();
    press_row = -1; press_cols = 3'b000;
    s_rst = 1'b1; s_rd = 1'b0; s_clr = 1'b0;
    C = 1'b0; A = 1'b0; E = 1'b0; rst = 1'b1; key_rd = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    cycle(); cycle();
    s_rst = 1'b0;
    check("rst_rows", 16'({D, F, G, B}), 16'h0001);
    check("rst_valid", 16'(key_valid), 16'd0);
    check("rst_data", 16'(key_data), 16'd13);
    check("rst_int", 16'(key_int), 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);

    // idle scanning: one row step every four clocks
    for (int k = 1; k <= 10; k++) begin
      repeat (4) cycle();
      check("idle_rows", 16'({D, F, G, B}), 16'(4'b0001 << (k % 4)));
    end
    check("idle_valid", 16'(key_valid), 16'd0);
    check("idle_data", 16'(key_data), 16'd13);

    // key 5 held on row G: one push, row parked on G
    wait_row(1);
    c0 = int_cnt;
    press_row = 1; press_cols = 3'b010;
    repeat (20) cycle();
    check("held_rows", 16'({D, F, G, B}), 16'h0002);
    check("held_data", 16'(key_data), 16'd5);
    check("held_int_pulses", 16'(int_cnt - c0), 16'd1);
    press_row = -1;
    repeat (20) cycle();
    check("rel_int_pulses", 16'(int_cnt - c0), 16'd1);
    pop_one();
    check("pop5_valid", 16'(key_valid), 16'd0);

    // one-tick glitch on row D
    wait_row(3);
    c0 = int_cnt;
    press_row = 3; press_cols = 3'b100;
    repeat (4) cycle();
    press_row = -1;
    repeat (4) cycle();
    check("glitch_rows", 16'({D, F, G, B}), 16'h0001);
    check("glitch_valid", 16'(key_valid), 16'd0);
    check("glitch_int", 16'(int_cnt - c0), 16'd0);

    // five presses into a four-entry buffer
    for (int i = 0; i < 5; i++) begin
      press(pv[i].row, pv[i].cols, 40, 40);
      check("vec_data", 16'(key_data), 16'(pv[i].exp_data));
      check("vec_valid", 16'(key_valid), 16'(pv[i].exp_valid));
      check("vec_ovf", 16'(overflow), 16'(pv[i].exp_ovf));
    end

    // clear coinciding with a fresh drop keeps overflow set
    c0 = int_cnt;
    press_sync(2, 3'b010, 1'b0, 1'b1, found);
    check("ovf_coincident", 16'(overflow), 16'd1);
    check("drop_no_int", 16'(int_cnt - c0), 16'd0);
    press(2, 3'b010, 10, 40);
    s_clr = 1'b1; cycle(); s_clr = 1'b0;
    check("ovf_cleared", 16'(overflow), 16'd0);
    check("drop_kept_head", 16'(key_data), 16'd1);

    for (int i = 0; i < 4; i++) begin
      pop_one();
      check("pop_data", 16'(key_data), 16'(popv[i].exp_data));
      check("pop_valid", 16'(key_valid), 16'(popv[i].exp_valid));
    end
    pop_one();
    check("pop_empty_ignored", 16'(key_data), 16'd13);

    // full buffer: push of 9 together with a pop
    for (int i = 0; i < 4; i++) press(pv[i].row, pv[i].cols, 40, 40);
    check("refill_head", 16'(key_data), 16'd1);
    check("refill_ovf", 16'(overflow), 16'd0);
    c0 = int_cnt;
    press_sync(2, 3'b100, 1'b1, 1'b0, found);
    check("pushpop_head", 16'(key_data), 16'd2);
    check("pushpop_int", 16'(int_cnt - c0), 16'd1);
    check("pushpop_ovf", 16'(overflow), 16'd0);
    press(2, 3'b100, 10, 40);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 16'(key_data), 16'(exp9[i]));
      pop_one();
    end
    check("drain_valid", 16'(key_valid), 16'd0);

    // reset in the middle of debouncing key 7, alongside rd and clr
    press_row = 2; press_cols = 3'b001;
    for (int n = 0; n < 80 && m_phase != P_CONF; n++) cycle();
    s_rst = 1'b1; s_rd = 1'b1; s_clr = 1'b1;
    cycle();
    s_rst = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
    press_row = -1;
    check("rst7_rows", 16'({D, F, G, B}), 16'h0001);
    check("rst7_valid", 16'(key_valid), 16'd0);
    check("rst7_data", 16'(key_data), 16'd13);
    check("rst7_int", 16'(key_int), 16'd0);
    check("rst7_ovf", 16'(overflow), 16'd0);
    repeat (40) cycle();
    check("rst7_no_push", 16'(key_valid), 16'd0);

    // random key activity, reads, clears and occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      int r;
      r = $urandom_range(0, 4);
      press_row  = (r == 4) ? -1 : r;
      press_cols = 3'($urandom_range(1, 7));
      repeat ($urandom_range(4, 40)) begin
        s_rd  = ($urandom_range(0, 5) == 0);
        s_clr = ($urandom_range(0, 20) == 0);
        s_rst = ($urandom_range(0, 400) == 0);
        cycle();
      end
    end
    s_rd = 1'b0; s_clr = 1'b0; s_rst = 1'b0; press_row = -1;
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_ctrl.md
KEYPAD_CTRL -- requirements
Module: keypad_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, 16'd50000, clk cycles per row-scan tick (min 2).
REQ-002 SHALL have parameter DEB_TICKS, 4, consecutive scan ticks a column reading must be stable to accept press/release (min 1).
REQ-003 SHALL have parameter FIFO_DEPTH, 4, key-code buffer entries (power of 2, min 2).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 C, A, E  input  1 each  keypad columns, high = connected to driven row.
REQ-007 B, G, F, D  output  1 each  keypad rows, one-hot when scanning, registered.
REQ-008 key_valid  output  1  FIFO non-empty.
REQ-009 key_data  output  4  FIFO head code; 4'd13 when empty.
REQ-010 key_rd  input  1  pop request from CPU port.
REQ-011 key_int  output  1  one-cycle pulse when a code is written into FIFO.
REQ-012 overflow  output  1  sticky; set when a code is dropped because FIFO is full.
REQ-013 ovf_clr  input  1  clears overflow.

Function
REQ-014 Prescaler SHALL count 0..SCAN_DIV-1 and assert internal tick for one cycle at terminal count.
REQ-015 States SHALL be SCAN, DEB_PRESS, HELD, DEB_REL.
REQ-016 SCAN: on each tick, row SHALL advance B->G->F->D->B; columns sampled the cycle of the tick (for the currently driven row).
REQ-017 SCAN: if any column high at a tick, SHALL latch row index and code, zero debounce count, enter DEB_PRESS without advancing row.
REQ-018 Code map: B row C/A/E = 1/2/3; G = 4/5/6; F = 7/8/9; D = 10/11/12; column priority C > A > E.
REQ-019 DEB_PRESS: each tick with same code SHALL increment count; at DEB_TICKS SHALL push code, enter HELD; any tick with different/no code SHALL return to SCAN and advance row.
REQ-020 HELD: row held; tick with no column high SHALL zero count, enter DEB_REL; no repeat codes emitted.
REQ-021 DEB_REL: DEB_TICKS consecutive empty ticks SHALL return to SCAN advancing row; any column high SHALL return to HELD.
REQ-022 Push latency: code SHALL appear at key_data (if FIFO was empty) and key_valid SHALL rise the cycle after the accepting tick; key_int pulses that same cycle.
REQ-023 key_rd with key_valid low SHALL be ignored; key_rd pops head, next entry visible next cycle.
REQ-024 Simultaneous push and pop SHALL both succeed, count unchanged, including when full.
REQ-025 Push while full without simultaneous pop SHALL drop the new code, set overflow, keep contents; key_int not pulsed.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-027 ovf_clr coincident with a new overflow event SHALL leave overflow set.

Reset
REQ-028 rst SHALL force: state SCAN, row B driven (B=1, G=F=D=0), prescaler 0, debounce count 0, FIFO empty, key_valid 0, key_data 13, key_int 0, overflow 0.
REQ-029 rst mid-debounce or mid-HELD SHALL discard the pending key; no push occurs.
REQ-030 rst SHALL take priority over key_rd, ovf_clr and ticks in the same cycle.

Structure
REQ-031 State enum, code constants (KEY_NONE=13, KEY_STAR=10, KEY_ZERO=11, KEY_HASH=12) SHALL live in shared package keypad_pkg.
REQ-032 FIFO SHALL be sub-module key_fifo (parameter DEPTH, width 4, push/pop/full/empty/overflow-free).
REQ-033 Scanner FSM, prescaler and debounce SHALL remain in keypad_ctrl.

Verification (SCAN_DIV=4, DEB_TICKS=2, FIFO_DEPTH=4)
REQ-034 Reset then idle 40 cycles -> rows cycle B,G,F,D every 4 clk; key_valid 0; key_data 13.
REQ-035 A high while G driven, held 20 cycles -> single push of 5; key_int one pulse; rows stay G until release debounced.
REQ-036 E high for 1 tick only (glitch) on row D -> no push; scanning resumes at F... next row after D is B.
REQ-037 Five distinct presses (1,2,3,4,6) without key_rd -> FIFO holds 1,2,3,4; overflow=1; pops return 1,2,3,4 then key_valid 0.
REQ-038 FIFO full, push of 9 coincident with key_rd -> pop returns 1, 9 stored, overflow stays 0.
REQ-039 rst asserted during DEB_PRESS for code 7 -> no code stored; outputs at reset values next cycle.
